// File: rtl/if_id_skid_stage.sv
// ---------------------------------------------------------------------------
// if_id_skid_stage
//   IF/ID pipeline stage with a valid/ready handshake and a 2-entry skid
//   buffer. The main register M drives the decode side and the skid
//   register S absorbs one extra instruction when decode stalls. When decode
//   stalls, instructions are held rather than dropped. Flush squashes
//   everything held. A saturating counter records bubble cycles, where decode
//   was ready but nothing was valid.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset (0 = reset)
//   flush      in   squash all held entries (branch/jump redirect)
//   in_valid   in   fetch presents in_pc/in_instr
//   in_pc      in   [XLEN-1:0] fetch PC
//   in_instr   in   [ILEN-1:0] fetched instruction
//   in_ready   out  stage can accept this cycle (registered state only)
//   out_valid  out  head entry valid
//   out_ready  in   decode accepts (0 = hazard stall)
//   out_pc     out  [XLEN-1:0] PC of head entry
//   out_instr  out  [ILEN-1:0] head instruction, NOP_INSTR when empty
//   out_rs1    out  [4:0] out_instr[19:15]
//   out_rs2    out  [4:0] out_instr[24:20]
//   out_rd     out  [4:0] out_instr[11:7]
//   bubble_cnt out  [CNT_W-1:0] saturating count of bubble cycles
// ---------------------------------------------------------------------------
module if_id_skid_stage #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = 'h00000013,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [ILEN-1:0]  in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [ILEN-1:0]  out_instr,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t             state_reg, state_next;
  logic [XLEN-1:0]    m_pc_reg, s_pc_reg;
  logic [ILEN-1:0]    m_instr_reg, s_instr_reg;
  logic [CNT_W-1:0]   bubble_cnt_reg;

  logic accept, issue, bubble;
  logic m_load_in, m_load_s, m_clear, s_load;

  // Handshake depends on registered state only, so there is no
  // combinational path from out_ready to in_ready.
  assign out_valid = (state_reg != EMPTY);
  assign in_ready  = (state_reg != FULL);
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;
  assign bubble    = out_ready & ~out_valid;

  assign out_pc     = m_pc_reg;
  assign out_instr  = m_instr_reg;
  assign out_rs1    = m_instr_reg[19:15];
  assign out_rs2    = m_instr_reg[24:20];
  assign out_rd     = m_instr_reg[11:7];
  assign bubble_cnt = bubble_cnt_reg;

  // Next-state and register-load selection. M always holds the oldest
  // entry, so S only ever moves into M and is never presented directly.
  always_comb begin
    state_next = state_reg;
    m_load_in  = 1'b0;
    m_load_s   = 1'b0;
    m_clear    = 1'b0;
    s_load     = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          m_load_in  = 1'b1;
        end
      end
      ONE: begin
        if (accept && issue) begin
          m_load_in = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          s_load     = 1'b1;
        end else if (issue) begin
          state_next = EMPTY;
          m_clear    = 1'b1;
        end
      end
      FULL: begin
        if (issue) begin
          state_next = ONE;
          m_load_s   = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
        m_clear    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= EMPTY;
      m_pc_reg       <= '0;
      m_instr_reg    <= NOP_INSTR;
      s_pc_reg       <= '0;
      s_instr_reg    <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      // Bubble counting is independent of flush; it saturates at all-ones.
      if (bubble && (bubble_cnt_reg != {CNT_W{1'b1}})) begin
        bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
      end

      if (flush) begin
        // A same-cycle accept is dropped; a same-cycle issue has already
        // been taken by decode, so discarding M is still correct.
        state_reg   <= EMPTY;
        m_pc_reg    <= '0;
        m_instr_reg <= NOP_INSTR;
        s_pc_reg    <= '0;
        s_instr_reg <= '0;
      end else begin
        state_reg <= state_next;
        if (m_load_in) begin
          m_pc_reg    <= in_pc;
          m_instr_reg <= in_instr;
        end else if (m_load_s) begin
          m_pc_reg    <= s_pc_reg;
          m_instr_reg <= s_instr_reg;
        end else if (m_clear) begin
          m_pc_reg    <= '0;
          m_instr_reg <= NOP_INSTR;
        end
        if (s_load) begin
          s_pc_reg    <= in_pc;
          s_instr_reg <= in_instr;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          CW  = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_pc, in_instr, out_pc, out_instr;
  logic [4:0]    out_rs1, out_rs2, out_rd;
  logic [CW-1:0] bubble_cnt;

  if_id_skid_stage #(
    .XLEN(32), .ILEN(32), .NOP_INSTR(NOP), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: entries pushed when the stage accepts, popped when decode
  // takes them.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  int   model_cnt = 0;
  int   n_total   = 0;
  int   n_pass    = 0;
  int   step_no   = 0;

  typedef struct {
    logic        rst_n, fl, iv;
    logic [31:0] pc, instr;
    logic        ordy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_ready;
  } vec_t;

  vec_t tbl[21];

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {pc[11:0], 20'h00093};  // addi x1,x0,pc
  endfunction

  function automatic vec_t mk(input logic rst_n, fl, iv, input logic [31:0] pc, instr,
                              input logic ordy, ev, input logic [31:0] epc, input logic er);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_ready = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (step %0d)", name, act, exp, step_no);
  endtask

  // One clock of stimulus. Inputs are driven at the falling edge, the
  // scoreboard is updated from the pre-edge model state, and outputs are
  // compared at the next falling edge.
  task automatic step(input logic rst_n, fl, iv, input logic [31:0] pc, instr, input logic ordy);
    logic  m_issue, m_accept;
    ent_t  e, head;
    logic [31:0] exp_instr;
    reset = rst_n; flush = fl; in_valid = iv; in_pc = pc; in_instr = instr; out_ready = ordy;
    #1;
    m_issue  = (q.size() > 0) && ordy;
    m_accept = iv && (q.size() < 2);
    if (rst_n && m_issue) begin
      e = q[0];
      chk("issue_pc", out_pc, e.pc);
      chk("issue_instr", out_instr, e.instr);
    end
    if (!rst_n) begin
      q.delete();
      model_cnt = 0;
    end else begin
      if (ordy && q.size() == 0 && model_cnt != (2**CW - 1)) model_cnt++;
      if (fl) q.delete();
      else begin
        if (m_issue) void'(q.pop_front());
        if (m_accept) begin
          e.pc = pc; e.instr = instr;
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    step_no++;
    if (q.size() > 0) head = q[0];
    else begin head.pc = 32'h0; head.instr = NOP; end
    exp_instr = head.instr;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_pc", out_pc, head.pc);
    chk("out_instr", out_instr, exp_instr);
    chk("out_rs1", 32'(out_rs1), 32'(exp_instr[19:15]));
    chk("out_rs2", 32'(out_rs2), 32'(exp_instr[24:20]));
    chk("out_rd", 32'(out_rd), 32'(exp_instr[11:7]));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(model_cnt));
    $display("step %0d rst=%b fl=%b iv=%b pc=%h ordy=%b -> v=%b rdy=%b out_pc=%h instr=%h cnt=%0d",
             step_no, rst_n, fl, iv, pc, ordy, out_valid, in_ready, out_pc, out_instr, bubble_cnt);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;

    //               rst fl iv pc        instr          ordy  v  exp_pc    rdy
    // reset then stream
    tbl[0]  = mk(0, 0, 0, 32'h00, 32'h0,          1, 0, 32'h00, 1);
    tbl[1]  = mk(0, 0, 0, 32'h00, 32'h0,          1, 0, 32'h00, 1);
    tbl[2]  = mk(1, 0, 1, 32'h00, 32'h00500093,   1, 1, 32'h00, 1);
    tbl[3]  = mk(1, 0, 1, 32'h04, 32'h00A00113,   1, 1, 32'h04, 1);
    tbl[4]  = mk(1, 0, 1, 32'h08, 32'h002081B3,   1, 1, 32'h08, 1);
    tbl[5]  = mk(1, 0, 0, 32'h00, 32'h0,          1, 0, 32'h00, 1);
    // stall fill
    tbl[6]  = mk(1, 0, 1, 32'h10, ins(32'h10),    1, 1, 32'h10, 1);
    tbl[7]  = mk(1, 0, 1, 32'h14, ins(32'h14),    0, 1, 32'h10, 0);
    tbl[8]  = mk(1, 0, 1, 32'h18, ins(32'h18),    0, 1, 32'h10, 0);
    tbl[9]  = mk(1, 0, 1, 32'h18, ins(32'h18),    1, 1, 32'h14, 1);
    tbl[10] = mk(1, 0, 1, 32'h18, ins(32'h18),    1, 1, 32'h18, 1);
    tbl[11] = mk(1, 0, 0, 32'h00, 32'h0,          1, 0, 32'h00, 1);
    // flush while FULL
    tbl[12] = mk(1, 0, 1, 32'h30, ins(32'h30),    0, 1, 32'h30, 1);
    tbl[13] = mk(1, 0, 1, 32'h34, ins(32'h34),    0, 1, 32'h30, 0);
    tbl[14] = mk(1, 1, 1, 32'h40, ins(32'h40),    0, 0, 32'h00, 1);
    tbl[15] = mk(1, 0, 0, 32'h00, 32'h0,          0, 0, 32'h00, 1);
    // simultaneous accept and issue in ONE
    tbl[16] = mk(1, 0, 1, 32'h20, ins(32'h20),    0, 1, 32'h20, 1);
    tbl[17] = mk(1, 0, 1, 32'h24, ins(32'h24),    1, 1, 32'h24, 1);
    tbl[18] = mk(1, 0, 0, 32'h00, 32'h0,          1, 0, 32'h00, 1);
    // flush with a same-cycle issue and accept
    tbl[19] = mk(1, 0, 1, 32'h50, ins(32'h50),    0, 1, 32'h50, 1);
    tbl[20] = mk(1, 1, 1, 32'h54, ins(32'h54),    1, 0, 32'h00, 1);

    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst_n, tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].ordy);
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
      chk("tbl_pc", out_pc, tbl[i].exp_pc);
      chk("tbl_ready", 32'(in_ready), 32'(tbl[i].exp_ready));
      if (i == 4) begin
        chk("decode_rs1", 32'(out_rs1), 32'd1);
        chk("decode_rs2", 32'(out_rs2), 32'd2);
        chk("decode_rd", 32'(out_rd), 32'd3);
      end
    end

    // Bubble counter saturation from reset.
    step(0, 0, 0, 32'h0, 32'h0, 1);
    chk("bub_reset", 32'(bubble_cnt), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 0, 32'h0, 32'h0, 1);
      chk("bub_sat", 32'(bubble_cnt), (k > 15) ? 32'd15 : 32'(k));
    end
    step(0, 0, 0, 32'h0, 32'h0, 1);
    chk("bub_reset2", 32'(bubble_cnt), 32'd0);

    // Reset mid-stream while FULL.
    step(1, 0, 0, 32'h0, 32'h0, 1);
    step(1, 0, 1, 32'h60, ins(32'h60), 0);
    step(1, 0, 1, 32'h64, ins(32'h64), 0);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(0, 0, 1, 32'h68, ins(32'h68), 1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_cnt", 32'(bubble_cnt), 32'd0);
    step(1, 0, 1, 32'h70, ins(32'h70), 1);
    chk("post_rst_pc", out_pc, 32'h70);
    step(1, 0, 0, 32'h0, 32'h0, 1);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
